jt2413_wrq: RTL and testbench

- Write-pacing queue placed directly upstream of the YM2413 core.
- Accepts CPU register writes at any rate into a small FIFO.
- Replays each write onto the core's din/addr/cs_n/wr_n bus, enforcing the chip's minimum spacing: ADDR_WAIT cen ticks after an address write, DATA_WAIT after a data write.
- Lets a fast host drive the core without software wait loops.

---
 rtl/jtopll_wrq_pkg.sv | 15 +
 rtl/jtopl_fifo.sv | 53 +++++
 rtl/jt2413_wrq.sv | 93 +++++++++
 tb/tb_jt2413_wrq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtopll_wrq_pkg.sv
// Shared types and constants for the YM2413 write-pacing queue.
// State encoding, default wait lengths and wait counter width.
package jtopll_wrq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STRB = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int ADDR_WAIT_DEF = 12;
  localparam int DATA_WAIT_DEF = 84;
  localparam int CNTW          = 7;

endpackage

// File: rtl/jtopl_fifo.sv
// Generic synchronous FIFO, 2^DW entries of W bits.
// A push while full is ignored; full is judged before the same-cycle pop.
module jtopl_fifo #(
  parameter int DW = 3,
  parameter int W  = 9
) (
  input  logic         rst,
  input  logic         clk,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << DW;

  logic [W-1:0]  mem [DEPTH];
  logic [DW-1:0] wr_ptr;
  logic [DW-1:0] rd_ptr;
  logic [DW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // count never exceeds DEPTH, so its MSB alone marks full
  assign full    = count[DW];
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/jt2413_wrq.sv
// Write-pacing queue in front of the YM2413 core: buffers host writes
// and replays them with the chip's minimum address/data spacing.
module jt2413_wrq
  import jtopll_wrq_pkg::*;
#(
  parameter int DW        = 3,
  parameter int ADDR_WAIT = ADDR_WAIT_DEF,
  parameter int DATA_WAIT = DATA_WAIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic [7:0] cpu_din,
  input  logic       cpu_addr,
  input  logic       cpu_wr,
  output logic       cpu_full,
  output logic       ovf,
  output logic       idle,
  output logic [7:0] din,
  output logic       addr,
  output logic       cs_n,
  output logic       wr_n
);

  localparam logic [CNTW-1:0] AWAIT_LD = CNTW'(ADDR_WAIT - 1);
  localparam logic [CNTW-1:0] DWAIT_LD = CNTW'(DATA_WAIT - 1);

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [8:0]      fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;
  logic            can_go;
  logic            pop;

  // the last wait tick may launch the next strobe directly
  assign can_go = (state == IDLE) |
                  ((state == WAIT) & (cnt == '0));
  assign pop      = cen & can_go & ~fifo_empty;
  assign cpu_full = fifo_full;
  assign idle     = fifo_empty & (state == IDLE);

  jtopl_fifo #(
    .DW (DW),
    .W  (9)
  ) u_fifo (
    .rst   (rst),
    .clk   (clk),
    .push  (cpu_wr),
    .pop   (pop),
    .din   ({cpu_addr, cpu_din}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      cs_n  <= 1'b1;
      wr_n  <= 1'b1;
      din   <= '0;
      addr  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (cpu_wr & fifo_full) ovf <= 1'b1;
      if (cen) begin
        unique case (state)
          IDLE, WAIT: begin
            if (pop) begin
              {addr, din} <= fifo_dout;
              cs_n        <= 1'b0;
              wr_n        <= 1'b0;
              state       <= STRB;
            end else if (state == WAIT) begin
              if (cnt == '0) state <= IDLE;
              else cnt <= cnt - 1'b1;
            end
          end
          STRB: begin
            cs_n  <= 1'b1;
            wr_n  <= 1'b1;
            cnt   <= addr ? DWAIT_LD : AWAIT_LD;
            state <= WAIT;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jt2413_wrq.sv
// Directed bench for jt2413_wrq: pacing, overflow, cen division,
// latency and asynchronous reset.
module tb_jt2413_wrq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cen;
  logic [7:0] cpu_din;
  logic       cpu_addr;
  logic       cpu_wr;
  logic       cpu_full;
  logic       ovf;
  logic       idle;
  logic [7:0] din;
  logic       addr;
  logic       cs_n;
  logic       wr_n;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic cen_val = 1'b1;
  logic div_en  = 1'b0;
  logic div_tick = 1'b0;
  int   dc = 0;

  int   n = 0;
  int   st_cyc  [64];
  int   st_len  [64];
  logic [7:0] st_din [64];
  logic       st_addr[64];
  logic prev_cs = 1'b1;

  jt2413_wrq u_dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .cpu_din  (cpu_din),
    .cpu_addr (cpu_addr),
    .cpu_wr   (cpu_wr),
    .cpu_full (cpu_full),
    .ovf      (ovf),
    .idle     (idle),
    .din      (din),
    .addr     (addr),
    .cs_n     (cs_n),
    .wr_n     (wr_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    dc = (dc == 3) ? 0 : dc + 1;
    div_tick = (dc == 0);
  end

  assign cen = div_en ? div_tick : cen_val;

  // strobe logger: start cycle, width in clk, bus values
  always @(negedge clk) begin
    if (rst) begin
      prev_cs = 1'b1;
    end else begin
      if (!cs_n && prev_cs && n < 64) begin
        st_cyc[n]  = cyc;
        st_din[n]  = din;
        st_addr[n] = addr;
      end
      if (cs_n && !prev_cs && n < 64) begin
        st_len[n] = cyc - st_cyc[n];
        n = n + 1;
      end
      prev_cs = cs_n;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic a, input logic [7:0] d);
    cpu_wr   = 1'b1;
    cpu_addr = a;
    cpu_din  = d;
    @(negedge clk);
    cpu_wr   = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    int k = 0;
    while (!idle && k < maxc) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    chk(tag, 32'(idle), 32'd1);
  endtask

  int c0;
  int nb;

  initial begin
    rst = 1'b1;
    cpu_wr = 1'b0;
    cpu_addr = 1'b0;
    cpu_din = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_wr_n", 32'(wr_n), 32'd1);
    chk("rst_din", 32'(din), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_full", 32'(cpu_full), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // pacing and empty-push latency, cen high
    nb = n;
    c0 = cyc;
    write(1'b0, 8'h10);
    chk("lat_no_bypass", 32'(cs_n), 32'd1);
    chk("lat_idle_low", 32'(idle), 32'd0);
    write(1'b1, 8'h55);
    chk("lat_strobe", 32'(cs_n), 32'd0);
    chk("lat_wr_n", 32'(wr_n), 32'd0);
    write(1'b0, 8'h20);
    wait_idle(400, "pace_drain");
    chk("pace_count", 32'(n - nb), 32'd3);
    chk("pace_t0", 32'(st_cyc[nb] - c0), 32'd2);
    chk("pace_t13", 32'(st_cyc[nb+1] - st_cyc[nb]), 32'd13);
    chk("pace_t98", 32'(st_cyc[nb+2] - st_cyc[nb]), 32'd98);
    chk("pace_din0", 32'(st_din[nb]), 32'h10);
    chk("pace_addr0", 32'(st_addr[nb]), 32'd0);
    chk("pace_din1", 32'(st_din[nb+1]), 32'h55);
    chk("pace_addr1", 32'(st_addr[nb+1]), 32'd1);
    chk("pace_din2", 32'(st_din[nb+2]), 32'h20);
    chk("pace_addr2", 32'(st_addr[nb+2]), 32'd0);
    for (int i = 0; i < 3; i++)
      chk("pace_len", 32'(st_len[nb+i]), 32'd1);

    // push at full coinciding with the IDLE->STRB pop
    cen_val = 1'b0;
    for (int i = 0; i < 8; i++) write(1'b1, 8'(8'h80 + i));
    chk("pf_full", 32'(cpu_full), 32'd1);
    chk("pf_ovf_pre", 32'(ovf), 32'd0);
    nb = n;
    cen_val = 1'b1;
    write(1'b1, 8'hEE);
    chk("pf_ovf", 32'(ovf), 32'd1);
    chk("pf_full_7", 32'(cpu_full), 32'd0);
    chk("pf_strobe", 32'(cs_n), 32'd0);
    wait_idle(1500, "pf_drain");
    chk("pf_count", 32'(n - nb), 32'd8);
    chk("pf_last", 32'(st_din[n-1]), 32'h87);

    rst = 1'b1;
    @(negedge clk);
    chk("rst_ovf_clr", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // fill with cen low, overflow on the ninth write
    cen_val = 1'b0;
    for (int i = 0; i < 8; i++) write(1'(i), 8'(8'h40 + i));
    chk("ovf_full8", 32'(cpu_full), 32'd1);
    chk("ovf_pre", 32'(ovf), 32'd0);
    write(1'b1, 8'h99);
    chk("ovf_set", 32'(ovf), 32'd1);
    nb = n;
    cen_val = 1'b1;
    wait_idle(1500, "ovf_drain");
    chk("ovf_count", 32'(n - nb), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_din", 32'(st_din[nb+i]), 32'(8'h40 + i));
      chk("ovf_addr", 32'(st_addr[nb+i]), 32'(i & 1));
    end
    chk("ovf_sticky", 32'(ovf), 32'd1);

    // cen divided by four
    div_en = 1'b1;
    nb = n;
    write(1'b1, 8'h01);
    write(1'b1, 8'h02);
    wait_idle(1200, "div_drain");
    chk("div_count", 32'(n - nb), 32'd2);
    chk("div_len", 32'(st_len[nb]), 32'd4);
    chk("div_gap", 32'(st_cyc[nb+1] - st_cyc[nb]), 32'd340);
    chk("div_din", 32'(st_din[nb+1]), 32'h02);
    div_en = 1'b0;
    cen_val = 1'b1;

    // asynchronous reset in the middle of a wait
    write(1'b1, 8'h77);
    repeat (20) @(negedge clk);
    chk("mw_pre_din", 32'(din), 32'h77);
    chk("mw_pre_idle", 32'(idle), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mw_cs_n", 32'(cs_n), 32'd1);
    chk("mw_wr_n", 32'(wr_n), 32'd1);
    chk("mw_din", 32'(din), 32'd0);
    chk("mw_addr", 32'(addr), 32'd0);
    chk("mw_idle", 32'(idle), 32'd1);
    chk("mw_ovf", 32'(ovf), 32'd0);
    chk("mw_full", 32'(cpu_full), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
